// File: rtl/centroid_pkg.sv
// Shared types for the centroid engine: FSM state encoding and accumulator width helper.
package centroid_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV   = 2'd1,
        EMPTY = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Sums must hold up to (2^COUNT_WIDTH-1) coordinates of DATA_WIDTH bits each.
    function automatic int sum_width(input int data_width, input int count_width);
        return data_width + count_width;
    endfunction

endpackage

// File: rtl/centroid_seq_if.sv
// Pixel-in / result-out bundle for centroid_seq; bbox fields exist only with CENTROID_BBOX_EN.
interface centroid_seq_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_x;
    logic [DATA_WIDTH-1:0]  in_y;
    logic                   in_hit;
    logic                   in_last;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  out_x;
    logic [DATA_WIDTH-1:0]  out_y;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_empty;
    logic                   out_ovf;
`ifdef CENTROID_BBOX_EN
    logic [DATA_WIDTH-1:0]  out_xmin;
    logic [DATA_WIDTH-1:0]  out_xmax;
    logic [DATA_WIDTH-1:0]  out_ymin;
    logic [DATA_WIDTH-1:0]  out_ymax;
`endif

    modport master (
        output in_valid, in_x, in_y, in_hit, in_last,
        input  in_ready, out_valid, out_x, out_y, out_count, out_empty, out_ovf
`ifdef CENTROID_BBOX_EN
        , input out_xmin, out_xmax, out_ymin, out_ymax
`endif
    );

    modport slave (
        input  in_valid, in_x, in_y, in_hit, in_last,
        output in_ready, out_valid, out_x, out_y, out_count, out_empty, out_ovf
`ifdef CENTROID_BBOX_EN
        , output out_xmin, out_xmax, out_ymin, out_ymax
`endif
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses after WIDTH iterations.
module seq_divider #(
    parameter int WIDTH   = 32,
    parameter int Q_WIDTH = WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [Q_WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div_r;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // A set MSB in diff means the trial subtraction borrowed, so the remainder is restored.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign diff     = shifted - {1'b0, div_r};
    assign quotient = quo[Q_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem       <= '0;
            quo       <= '0;
            div_r     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem       <= '0;
                quo       <= dividend;
                div_r     <= divisor;
                remaining <= CNT_W'(WIDTH);
                busy      <= 1'b1;
            end else if (busy) begin
                if (!diff[WIDTH]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                remaining <= remaining - 1'b1;
                if (remaining == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/centroid_seq.sv
// Per-frame centroid of hit pixels using two sequential dividers (x, y).
// Define CENTROID_BBOX_EN to add min/max bounding-box outputs.
module centroid_seq
    import centroid_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 24
) (
    input logic           clk,
    input logic           rst_n,
    centroid_seq_if.slave bus
);
    localparam int SUM_WIDTH = sum_width(DATA_WIDTH, COUNT_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    state_t                 state, next_state;
    logic [SUM_WIDTH-1:0]   sum_x, sum_y, next_sum_x, next_sum_y, divisor;
    logic [COUNT_WIDTH-1:0] count, next_count;
    logic                   ovf;
    logic                   beat_fire, hit_fire, frame_end, div_start, load_result;
    logic                   x_busy, y_busy, x_done, y_done;
    logic [DATA_WIDTH-1:0]  quot_x, quot_y;

    assign beat_fire = bus.in_valid && bus.in_ready;
    assign hit_fire  = beat_fire && bus.in_hit;
    assign frame_end = beat_fire && bus.in_last;
    assign div_start = frame_end && (next_count != '0);
    assign divisor   = SUM_WIDTH'(next_count);

    // Dividers start on the in_last edge itself, fed with the totals that include that beat.
    always_comb begin
        next_sum_x = sum_x;
        next_sum_y = sum_y;
        next_count = count;
        if (hit_fire && (count != COUNT_MAX)) begin
            next_sum_x = sum_x + SUM_WIDTH'(bus.in_x);
            next_sum_y = sum_y + SUM_WIDTH'(bus.in_y);
            next_count = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (frame_end) next_state = (next_count != '0) ? DIV : EMPTY;
            DIV:     if (x_done && y_done) next_state = DONE;
            EMPTY:   next_state = DONE;
            DONE:    next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == ACCUM) && !x_busy && !y_busy;
        bus.out_valid = (state == DONE);
        load_result   = ((state == DIV) && x_done && y_done) || (state == EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == DONE) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            sum_x <= next_sum_x;
            sum_y <= next_sum_y;
            count <= next_count;
            if (hit_fire && (count == COUNT_MAX)) ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_x     <= '0;
            bus.out_y     <= '0;
            bus.out_count <= '0;
            bus.out_empty <= 1'b0;
            bus.out_ovf   <= 1'b0;
        end else if (load_result) begin
            bus.out_x     <= (state == EMPTY) ? '0 : quot_x;
            bus.out_y     <= (state == EMPTY) ? '0 : quot_y;
            bus.out_count <= count;
            bus.out_empty <= (state == EMPTY);
            bus.out_ovf   <= ovf;
        end
    end

    seq_divider #(.WIDTH(SUM_WIDTH), .Q_WIDTH(DATA_WIDTH)) div_x (
        .clk(clk), .rst_n(rst_n), .start(div_start),
        .dividend(next_sum_x), .divisor(divisor),
        .busy(x_busy), .done(x_done), .quotient(quot_x)
    );

    seq_divider #(.WIDTH(SUM_WIDTH), .Q_WIDTH(DATA_WIDTH)) div_y (
        .clk(clk), .rst_n(rst_n), .start(div_start),
        .dividend(next_sum_y), .divisor(divisor),
        .busy(y_busy), .done(y_done), .quotient(quot_y)
    );

`ifdef CENTROID_BBOX_EN
    logic [DATA_WIDTH-1:0] xmin, xmax, ymin, ymax;

    // Box keeps growing after count saturation; min registers idle at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xmin <= '1;
            xmax <= '0;
            ymin <= '1;
            ymax <= '0;
        end else if (state == DONE) begin
            xmin <= '1;
            xmax <= '0;
            ymin <= '1;
            ymax <= '0;
        end else if (hit_fire) begin
            if (bus.in_x < xmin) xmin <= bus.in_x;
            if (bus.in_x > xmax) xmax <= bus.in_x;
            if (bus.in_y < ymin) ymin <= bus.in_y;
            if (bus.in_y > ymax) ymax <= bus.in_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_xmin <= '0;
            bus.out_xmax <= '0;
            bus.out_ymin <= '0;
            bus.out_ymax <= '0;
        end else if (load_result) begin
            bus.out_xmin <= (state == EMPTY) ? '0 : xmin;
            bus.out_xmax <= (state == EMPTY) ? '0 : xmax;
            bus.out_ymin <= (state == EMPTY) ? '0 : ymin;
            bus.out_ymax <= (state == EMPTY) ? '0 : ymax;
        end
    end
`endif

endmodule
